// File: rtl/hus_pkg.sv
// Shared types and constants for the HUS frame scheduler: FSM states,
// frame timing, channel limits and register-file layout.
package hus_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_BURST,
        ST_MATH
    } st_e;

    // 24 MHz system clock divided down to the 44.1 kHz audio tick
    localparam int AU_DIV       = 544;

    localparam int CHN_MAX      = 32;
    localparam int CHN_W        = 6;

    // Each channel owns REGS_PER_CHN consecutive 16-bit registers
    localparam int REGS_PER_CHN = 8;
    localparam int RSEL_W       = $clog2(REGS_PER_CHN);
    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 16;

    localparam logic [RSEL_W-1:0] MATH_REG = 3'd0;

    function automatic logic [CHN_W-1:0] clamp_chn(input logic [CHN_W-1:0] n);
        return (int'(n) > CHN_MAX) ? CHN_W'(CHN_MAX) : n;
    endfunction

    function automatic logic [ADDR_W-1:0] par_addr(input logic [4:0] chn);
        return {chn, MATH_REG};
    endfunction

endpackage

// File: rtl/hus_au_tick.sv
// Audio tick divider: a free-running count of PERIOD cycles while enabled,
// pulsing frame_stb on the last count of each period.
module hus_au_tick
    import hus_pkg::*;
#(
    parameter int PERIOD = AU_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic frame_stb
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_stb = en && (cnt_q == LAST);

endmodule

// File: rtl/hus_seq.sv
// HUS mixer frame scheduler: per audio tick, a fetch burst over the active
// channels followed by a parameter-read pass, sharing the register-file port.
module hus_seq
    import hus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CHN_W-1:0]  chn_num,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              burst_req,
    output logic [CHN_W-1:0]  burst_chn,
    input  logic              burst_ack,
    output logic              math_vld,
    output logic [CHN_W-1:0]  math_chn,
    output logic [DATA_W-1:0] math_par,
    output logic              frame_stb,
    output logic              frame_done,
    output logic              ovr
);

    st_e               state_q, state_d;
    logic [CHN_W-1:0]  chn_q, chn_d;
    logic [CHN_W-1:0]  lim_q, lim_d;
    logic              math_vld_q, math_vld_d;
    logic [CHN_W-1:0]  math_chn_q, math_chn_d;
    logic [DATA_W-1:0] math_par_q, math_par_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;

    logic              tick;
    logic              last_chn;
    logic [CHN_W-1:0]  lim_new;

    hus_au_tick #(
        .PERIOD (AU_DIV)
    ) u_au_tick (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .frame_stb (tick)
    );

    assign last_chn = (chn_q == lim_q - CHN_W'(1));
    assign lim_new  = clamp_chn(chn_num);

    always_comb begin
        state_d    = state_q;
        chn_d      = chn_q;
        lim_d      = lim_q;
        math_vld_d = 1'b0;
        math_chn_d = math_chn_q;
        math_par_d = math_par_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;

        if (!en) begin
            state_d = ST_OFF;
            chn_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            // A tick that lands mid-frame is dropped; the frame runs to completion
            if (tick && (state_q != ST_IDLE)) begin
                ovr_d = 1'b1;
            end

            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_IDLE;
                end

                ST_IDLE: begin
                    if (tick) begin
                        lim_d = lim_new;
                        chn_d = '0;
                        if (lim_new == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_BURST;
                        end
                    end
                end

                ST_BURST: begin
                    if (burst_ack) begin
                        if (last_chn) begin
                            state_d = ST_MATH;
                            chn_d   = '0;
                        end else begin
                            chn_d = chn_q + CHN_W'(1);
                        end
                    end
                end

                ST_MATH: begin
                    // Host writes own the port; the read simply retries next cycle
                    if (!host_wr) begin
                        math_vld_d = 1'b1;
                        math_chn_d = chn_q;
                        math_par_d = ram_rdata;
                        if (last_chn) begin
                            state_d = ST_IDLE;
                            chn_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            chn_d = chn_q + CHN_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OFF;
            chn_q      <= '0;
            lim_q      <= '0;
            math_vld_q <= 1'b0;
            math_chn_q <= '0;
            math_par_q <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chn_q      <= chn_d;
            lim_q      <= lim_d;
            math_vld_q <= math_vld_d;
            math_chn_q <= math_chn_d;
            math_par_q <= math_par_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    // Register-file arbiter: host writes always win the single port
    assign ram_we    = host_wr;
    assign ram_wdata = host_wr ? host_data : '0;
    assign ram_addr  = host_wr               ? host_addr :
                       (state_q == ST_MATH)  ? par_addr(chn_q[4:0]) : '0;

    assign burst_req  = (state_q == ST_BURST) && en;
    assign burst_chn  = (state_q == ST_BURST) ? chn_q : '0;

    // Dropping en squashes a result still in the output register
    assign math_vld   = math_vld_q && en;
    assign math_chn   = math_chn_q;
    assign math_par   = math_par_q;
    assign frame_done = done_q && en;
    assign frame_stb  = tick;
    assign ovr        = ovr_q;

endmodule
